fc_layer_tiled: RTL and testbench

Parametrised fully-connected layer engine, the successor to the fixed 64→10 inner-product layer. It buffers one input vector from the upstream blob stream. It then computes K_OUT outputs in tiles of KPF lanes. For each tile it fetches the bias and weights from external memory through the DMA engineer port, then emits one KPF-wide output beat per tile to the downstream blob stream. It sits between two layer blocks on the blob chain and shares the DMA engineer with the other layers.

---
 rtl/fc_layer_tiled_pkg.sv | 16 +
 rtl/fc_layer_tiled_mac_lane.sv | 65 ++++++
 rtl/fc_layer_tiled.sv | 123 ++++++++++++
 tb/tb_fc_layer_tiled.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_layer_tiled_pkg.sv
// fc_pkg: shared FSM state type and arithmetic helpers for fc_layer_tiled
package fc_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, REQ, FETCH, DRAIN, OUT} state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int dw);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        return x > hi ? hi : x < -hi - 64'sd1 ? -hi - 64'sd1 : x;
    endfunction

endpackage

// File: rtl/fc_layer_tiled_mac_lane.sv
// fc_mac_lane: one output lane (CPF multipliers, adder tree, accumulator, shift, saturate; ReLU under FC_RELU_EN)
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int DW        = 16,
    parameter int WW        = 16,
    parameter int CPF       = 4,
    parameter int ACC_WIDTH = 40,
    parameter int DIN_Q     = 6,
    parameter int WQ        = 13,
    parameter int DOUT_Q    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DW-1:0]     bias,
    input  logic              mac_en,
    input  logic [CPF*DW-1:0] x,
    input  logic [CPF*WW-1:0] w,
    output logic [DW-1:0]     res
);
    localparam int SH = DIN_Q + WQ - DOUT_Q;

    logic signed [DW+WW-1:0]    prod [CPF];
    logic                       pv;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [DW-1:0]       s;

    // stage 1: register the CPF full-precision products
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= 1'b0;
            for (int c = 0; c < CPF; c++) prod[c] <= '0;
        end else begin
            pv <= mac_en;
            if (mac_en)
                for (int c = 0; c < CPF; c++)
                    prod[c] <= (DW+WW)'($signed(x[c*DW +: DW])) * (DW+WW)'($signed(w[c*WW +: WW]));
        end
    end

    // adder tree over the registered products
    always_comb begin
        sum = '0;
        for (int c = 0; c < CPF; c++) sum = sum + ACC_WIDTH'(prod[c]);
    end

    // stage 2: bias preload aligned to the product scale, then accumulate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc <= '0;
        else      acc <= clr ? ACC_WIDTH'($signed(bias)) <<< SH : pv ? acc + sum : acc;
    end

    // rescale to output format, saturate, optional ReLU
    always_comb begin
        s = DW'(sat(64'(acc >>> SH), DW));
`ifdef FC_RELU_EN
        res = s[DW-1] ? '0 : s;
`else
        res = s;
`endif
    end

endmodule

// File: rtl/fc_layer_tiled.sv
// fc_layer_tiled: tiled fully-connected layer engine; define FC_RELU_EN to clamp lane outputs at zero
module fc_layer_tiled
    import fc_pkg::*;
#(
    parameter int C_IN       = 64,
    parameter int K_OUT      = 10,
    parameter int CPF        = 4,
    parameter int KPF        = 2,
    parameter int DW         = 16,
    parameter int WW         = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int DIN_Q      = 6,
    parameter int WQ         = 13,
    parameter int DOUT_Q     = 6,
    parameter int START_ADDR = 0,
    parameter int AW         = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CPF*DW-1:0]     blob_din,
    input  logic                  blob_din_en,
    input  logic                  blob_din_eop,
    output logic                  blob_din_rdy,
    output logic                  dma_engineer_req,
    input  logic                  dma_engineer_ack,
    output logic [AW-1:0]         dma_engineer_start_addr,
    output logic [AW-1:0]         dma_engineer_length,
    input  logic [KPF*CPF*WW-1:0] dma_engineer_dout,
    input  logic                  dma_engineer_dout_en,
    input  logic                  dma_engineer_dout_eop,
    output logic [KPF*DW-1:0]     blob_dout,
    output logic                  blob_dout_en,
    input  logic                  blob_dout_rdy,
    output logic                  blob_dout_eop
);
    localparam int NB = C_IN / CPF;
    localparam int NT = ceil_div(K_OUT, KPF);
    localparam int TL = 1 + NB;
    localparam int CW = $clog2(TL + 1);
    localparam int TW = $clog2(NT + 1);
    localparam int IW = NB > 1 ? $clog2(NB) : 1;

    if (C_IN % CPF != 0) begin : g_cin_check
        $error("C_IN must be a multiple of CPF");
    end

    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     tile;
    logic [CPF*DW-1:0] in_mem [NB];
    logic [CPF*DW-1:0] x_sel;
    logic              in_take, clr, mac_en, last_tile;
    logic              unused;

    assign unused    = ^{blob_din_eop, dma_engineer_dout_eop};
    assign last_tile = tile == TW'(NT - 1);
    assign x_sel     = in_mem[IW'(cnt - 1'b1)];

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // next state and control outputs
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = blob_din_en ? (NB == 1 ? REQ : LOAD) : IDLE;
            LOAD:    nxt = (blob_din_en && cnt == CW'(NB - 1)) ? REQ : LOAD;
            REQ:     nxt = dma_engineer_ack ? FETCH : REQ;
            FETCH:   nxt = (dma_engineer_dout_en && cnt == CW'(TL - 1)) ? DRAIN : FETCH;
            DRAIN:   nxt = cnt == CW'(2) ? OUT : DRAIN;
            OUT:     nxt = blob_dout_rdy ? (last_tile ? IDLE : REQ) : OUT;
            default: nxt = IDLE;
        endcase
        in_take                 = (state == IDLE || state == LOAD) && blob_din_en;
        blob_din_rdy            = rst && (state == IDLE || state == LOAD);
        dma_engineer_req        = state == REQ;
        dma_engineer_start_addr = state == REQ ? AW'(START_ADDR) + AW'(tile) * AW'(TL) : '0;
        dma_engineer_length     = state == REQ ? AW'(TL) : '0;
        clr                     = state == FETCH && dma_engineer_dout_en && cnt == '0;
        mac_en                  = state == FETCH && dma_engineer_dout_en && cnt != '0;
        blob_dout_en            = state == OUT;
        blob_dout_eop           = state == OUT && last_tile;
    end

    // beat counter (input beats, DMA beats, drain cycles) and tile index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tile <= '0;
        end else begin
            cnt  <= (nxt != state) ? CW'(state == IDLE) :
                    (in_take || clr || mac_en || state == DRAIN) ? cnt + 1'b1 : cnt;
            tile <= state == IDLE ? '0 : (state == OUT && blob_dout_rdy) ? tile + 1'b1 : tile;
        end
    end

    // input vector buffer; validity is tracked by the FSM, not by the contents
    always_ff @(posedge clk) begin
        if (in_take) in_mem[state == IDLE ? '0 : IW'(cnt)] <= blob_din;
    end

    for (genvar k = 0; k < KPF; k++) begin : g_lane
        logic [DW-1:0] res;
        fc_mac_lane #(
            .DW(DW), .WW(WW), .CPF(CPF), .ACC_WIDTH(ACC_WIDTH),
            .DIN_Q(DIN_Q), .WQ(WQ), .DOUT_Q(DOUT_Q)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .clr(clr),
            .bias(dma_engineer_dout[k*DW +: DW]),
            .mac_en(mac_en),
            .x(x_sel),
            .w(dma_engineer_dout[k*CPF*WW +: CPF*WW]),
            .res(res)
        );
        assign blob_dout[k*DW +: DW] = (state == OUT && int'(tile) * KPF + k < K_OUT) ? res : '0;
    end

endmodule

// File: tb/tb_fc_layer_tiled.sv
// tb_fc_layer_tiled: directed self-checking bench for fc_layer_tiled (C_IN=8, CPF=4, K_OUT=3, KPF=2)
module tb_fc_layer_tiled;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [63:0]  blob_din;
    logic         blob_din_en, blob_din_eop, blob_din_rdy;
    logic         req, ack;
    logic [26:0]  addr, len;
    logic [127:0] dma_dout;
    logic         dma_en, dma_eop;
    logic [31:0]  blob_dout;
    logic         dout_en, dout_rdy, dout_eop;
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    fc_layer_tiled #(.C_IN(8), .K_OUT(3), .CPF(4), .KPF(2)) dut (
        .clk(clk),
        .rst(rst),
        .blob_din(blob_din),
        .blob_din_en(blob_din_en),
        .blob_din_eop(blob_din_eop),
        .blob_din_rdy(blob_din_rdy),
        .dma_engineer_req(req),
        .dma_engineer_ack(ack),
        .dma_engineer_start_addr(addr),
        .dma_engineer_length(len),
        .dma_engineer_dout(dma_dout),
        .dma_engineer_dout_en(dma_en),
        .dma_engineer_dout_eop(dma_eop),
        .blob_dout(blob_dout),
        .blob_dout_en(dout_en),
        .blob_dout_rdy(dout_rdy),
        .blob_dout_eop(dout_eop)
    );

    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [127:0] wb(input logic [63:0] l0, input logic [63:0] l1);
        return {l1, l0};
    endfunction

    function automatic logic [127:0] bb(input int b0, input int b1);
        return {96'd0, 16'(b1), 16'(b0)};
    endfunction

    task automatic send_vec(input logic [63:0] v0, input logic [63:0] v1);
        @(negedge clk); blob_din = v0; blob_din_en = 1'b1; blob_din_eop = 1'b0;
        @(negedge clk); blob_din = v1; blob_din_eop = 1'b1;
        @(negedge clk); blob_din_en = 1'b0; blob_din_eop = 1'b0;
    endtask

    task automatic xfer(input logic [127:0] b0, input logic [127:0] w1, input logic [127:0] w2,
                        input int hold, output logic [26:0] a, output logic [26:0] l, output int cyc,
                        output logic [31:0] d, output logic e, output logic stable, output logic req_after);
        int t;
        t = 0; cyc = -1; a = '0; l = '0; d = '0; e = 1'b0; stable = 1'b0; req_after = 1'b0;
        while (!req && t < 50) begin @(negedge clk); t++; end
        if (!req) return;
        a = addr; l = len; ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        dma_dout = b0; dma_en = 1'b1;
        @(negedge clk); dma_dout = w1;
        @(negedge clk); dma_dout = w2; dma_eop = 1'b1;
        @(negedge clk); dma_en = 1'b0; dma_eop = 1'b0; dma_dout = '0;
        cyc = 0;
        while (!dout_en && cyc < 50) begin @(negedge clk); cyc++; end
        d = blob_dout; e = dout_eop; stable = dout_en;
        repeat (hold) begin
            @(negedge clk);
            if (!dout_en || blob_dout !== d || dout_eop !== e || req) stable = 1'b0;
        end
        dout_rdy = 1'b1;
        @(negedge clk); dout_rdy = 1'b0; req_after = req;
    endtask

    task automatic test_reset();
        blob_din_en = 1'b1; dma_en = 1'b1; dma_dout = '1; blob_din = '1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({blob_din_rdy, req, addr, len, blob_dout, dout_en, dout_eop} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b req=%b addr=%0d len=%0d dout=%h en=%b eop=%b, expected all 0",
                     blob_din_rdy, req, addr, len, blob_dout, dout_en, dout_eop);
        end
        blob_din_en = 1'b0; dma_en = 1'b0; dma_dout = '0; blob_din = '0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (blob_din_rdy !== 1'b1 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got rdy=%b req=%b, expected rdy=1 req=0", blob_din_rdy, req);
        end
    endtask

    task automatic test_basic();
        logic [26:0] a, l;
        int cyc;
        logic [31:0] d;
        logic e, st, ra;
        logic [127:0] w;
        w = wb(p4(8192, 8192, 8192, 8192), p4(8192, 8192, 8192, 8192));
        send_vec(p4(64, 64, 64, 64), p4(64, 64, 64, 64));
        n_tests++;
        if (blob_din_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_drop: got %b expected 0", blob_din_rdy); end
        xfer(bb(32, 32), w, w, 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (a !== 27'd0) begin n_fail++; $display("FAIL basic_addr0: got %0d expected 0", a); end
        n_tests++;
        if (l !== 27'd3) begin n_fail++; $display("FAIL basic_len0: got %0d expected 3", l); end
        n_tests++;
        if (cyc !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d cycles expected 3", cyc); end
        n_tests++;
        if (d !== {16'd544, 16'd544} || e !== 1'b0) begin
            n_fail++; $display("FAIL basic_tile0: got %h eop=%b expected %h eop=0", d, e, {16'd544, 16'd544});
        end
        n_tests++;
        if (ra !== 1'b1) begin n_fail++; $display("FAIL basic_next_req: got %b expected 1", ra); end
        xfer(bb(32, 32), w, w, 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (a !== 27'd3 || l !== 27'd3) begin n_fail++; $display("FAIL basic_addr1: got %0d/%0d expected 3/3", a, l); end
        n_tests++;
        if (d !== {16'd0, 16'd544} || e !== 1'b1) begin
            n_fail++; $display("FAIL basic_tile1: got %h eop=%b expected %h eop=1", d, e, {16'd0, 16'd544});
        end
        n_tests++;
        if (ra !== 1'b0 || blob_din_rdy !== 1'b1) begin
            n_fail++; $display("FAIL basic_idle: got req=%b rdy=%b expected req=0 rdy=1", ra, blob_din_rdy);
        end
    endtask

    task automatic test_saturation();
        logic [26:0] a, l;
        int cyc;
        logic [31:0] d, exp_neg;
        logic e, st, ra;
        logic [127:0] wp, wn;
        wp = wb(p4(8191, 8191, 8191, 8191), p4(8191, 8191, 8191, 8191));
        wn = wb(p4(-8191, -8191, -8191, -8191), p4(-8191, -8191, -8191, -8191));
`ifdef FC_RELU_EN
        exp_neg = 32'h0000_0000;
`else
        exp_neg = 32'h8000_8000;
`endif
        send_vec(p4(32767, 32767, 32767, 32767), p4(32767, 32767, 32767, 32767));
        xfer(bb(0, 0), wp, wp, 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (d !== 32'h7fff_7fff) begin n_fail++; $display("FAIL sat_pos_tile0: got %h expected 7fff7fff", d); end
        xfer(bb(0, 0), wp, wp, 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (d !== 32'h0000_7fff || e !== 1'b1) begin
            n_fail++; $display("FAIL sat_pos_tile1: got %h eop=%b expected 00007fff eop=1", d, e);
        end
        send_vec(p4(32767, 32767, 32767, 32767), p4(32767, 32767, 32767, 32767));
        xfer(bb(0, 0), wn, wn, 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (d !== exp_neg) begin n_fail++; $display("FAIL sat_neg_tile0: got %h expected %h", d, exp_neg); end
        xfer(bb(0, 0), wn, wn, 0, a, l, cyc, d, e, st, ra);
    endtask

    task automatic test_backpressure();
        logic [26:0] a, l;
        int cyc;
        logic [31:0] d;
        logic e, st, ra;
        logic [127:0] w;
        w = wb(p4(8192, 8192, 8192, 8192), p4(8192, 8192, 8192, 8192));
        send_vec(p4(64, 64, 64, 64), p4(64, 64, 64, 64));
        xfer(bb(32, 32), w, w, 10, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (st !== 1'b1 || d !== {16'd544, 16'd544}) begin
            n_fail++; $display("FAIL bp_tile0_stable: got stable=%b data=%h expected stable=1 data=02200220", st, d);
        end
        n_tests++;
        if (ra !== 1'b1) begin n_fail++; $display("FAIL bp_req_after: got %b expected 1", ra); end
        xfer(bb(32, 32), w, w, 10, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (st !== 1'b1 || e !== 1'b1 || d !== {16'd0, 16'd544} || ra !== 1'b0) begin
            n_fail++; $display("FAIL bp_tile1: got stable=%b eop=%b data=%h req=%b expected 1/1/00000220/0", st, e, d, ra);
        end
    endtask

    task automatic test_mixed();
        logic [26:0] a, l;
        int cyc;
        logic [31:0] d, exp1;
        logic e, st, ra;
`ifdef FC_RELU_EN
        exp1 = 32'h0000_0000;
`else
        exp1 = 32'h0000_ffca;
`endif
        send_vec(p4(64, 128, -64, 0), p4(32, 64, 64, 64));
        xfer(bb(0, -32), wb(p4(8192, 8192, 8192, 8192), p4(4096, 4096, 4096, 4096)),
             wb(p4(0, 8192, -8192, 16384), p4(0, 0, 0, 0)), 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (d !== {16'd32, 16'd256}) begin n_fail++; $display("FAIL mixed_tile0: got %h expected %h", d, {16'd32, 16'd256}); end
        xfer(bb(10, 100), wb(p4(-8192, 0, 0, 0), p4(8192, 8192, 8192, 8192)),
             wb(p4(0, 0, 0, 0), p4(8192, 8192, 8192, 8192)), 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (d !== exp1) begin n_fail++; $display("FAIL mixed_tile1: got %h expected %h", d, exp1); end
    endtask

    task automatic test_relu_bias();
        logic [26:0] a, l;
        int cyc;
        logic [31:0] d, exp0;
        logic e, st, ra;
`ifdef FC_RELU_EN
        exp0 = 32'h0000_0000;
`else
        exp0 = 32'hffc0_ffc0;
`endif
        send_vec(p4(64, 64, 64, 64), p4(64, 64, 64, 64));
        xfer(bb(-64, -64), '0, '0, 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (d !== exp0) begin n_fail++; $display("FAIL neg_bias_tile0: got %h expected %h", d, exp0); end
        xfer(bb(-64, -64), '0, '0, 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (d !== (exp0 & 32'h0000_ffff)) begin
            n_fail++; $display("FAIL neg_bias_tile1: got %h expected %h", d, exp0 & 32'h0000_ffff);
        end
    endtask

    task automatic test_reset_fetch();
        logic [26:0] a, l;
        int cyc, t;
        logic [31:0] d;
        logic e, st, ra;
        logic [127:0] w;
        w = wb(p4(8192, 8192, 8192, 8192), p4(8192, 8192, 8192, 8192));
        send_vec(p4(100, 100, 100, 100), p4(100, 100, 100, 100));
        t = 0;
        while (!req && t < 50) begin @(negedge clk); t++; end
        n_tests++;
        if (req !== 1'b1) begin n_fail++; $display("FAIL rstf_req_seen: got %b expected 1", req); end
        ack = 1'b1;
        @(negedge clk); ack = 1'b0; dma_dout = bb(5, 5); dma_en = 1'b1;
        @(negedge clk); dma_dout = w;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({blob_din_rdy, req, addr, len, blob_dout, dout_en, dout_eop} !== '0) begin
            n_fail++;
            $display("FAIL rstf_outputs: got rdy=%b req=%b addr=%0d len=%0d dout=%h en=%b eop=%b, expected all 0",
                     blob_din_rdy, req, addr, len, blob_dout, dout_en, dout_eop);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        dma_en = 1'b0; dma_dout = '0;
        n_tests++;
        if (req !== 1'b0 || blob_din_rdy !== 1'b1 || dout_en !== 1'b0) begin
            n_fail++; $display("FAIL rstf_idle: got req=%b rdy=%b en=%b expected 0/1/0", req, blob_din_rdy, dout_en);
        end
        send_vec(p4(64, 64, 64, 64), p4(64, 64, 64, 64));
        xfer(bb(32, 32), w, w, 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (a !== 27'd0 || d !== {16'd544, 16'd544}) begin
            n_fail++; $display("FAIL rstf_tile0: got addr=%0d data=%h expected 0/02200220", a, d);
        end
        xfer(bb(32, 32), w, w, 0, a, l, cyc, d, e, st, ra);
        n_tests++;
        if (d !== {16'd0, 16'd544} || e !== 1'b1) begin
            n_fail++; $display("FAIL rstf_tile1: got %h eop=%b expected 00000220 eop=1", d, e);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        blob_din = '0; blob_din_en = 1'b0; blob_din_eop = 1'b0;
        ack = 1'b0; dma_dout = '0; dma_en = 1'b0; dma_eop = 1'b0; dout_rdy = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_mixed();
        test_relu_bias();
        test_reset_fetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
